// File: rtl/mult8_pkg.sv
// rtl/mult8_pkg.sv - shared types and constants for the 8x8 shift-add multiplier
package mult8_pkg;

    localparam int WIDTH = 8;
    localparam int ITERS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder8bit.sv
// rtl/adder8bit.sv - 8-bit ripple-carry adder
module adder8bit (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    always_comb begin
        logic w_carry;
        w_carry = i_cin;
        o_sum   = '0;
        for (int i = 0; i < 8; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_carry;
    end

endmodule

// File: rtl/seq_mult8.sv
// rtl/seq_mult8.sv - sequential 8x8 unsigned shift-add multiplier with valid/ready handshakes
module seq_mult8
    import mult8_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    state_t              r_state;
    state_t              w_next_state;
    logic [2*WIDTH:0]    r_p;
    logic [WIDTH-1:0]    r_mcand;
    logic [3:0]          r_iter;
    logic [2*WIDTH-1:0]  r_product;

    logic [WIDTH-1:0]    w_sum;
    logic                w_cout;
    logic                w_c;
    logic [WIDTH-1:0]    w_acc;
    logic [2*WIDTH:0]    w_shifted;
    logic                w_last;

    adder8bit u_adder (
        .i_a    (r_p[15:8]),
        .i_b    (r_mcand),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Carry out of the add lands in bit 15 after the shift, so nothing is lost.
    assign {w_c, w_acc} = r_p[0] ? {w_cout, w_sum} : {1'b0, r_p[15:8]};
    assign w_shifted    = {1'b0, w_c, w_acc, r_p[7:1]};
    assign w_last       = (r_iter == 4'(ITERS - 1));
    assign product      = r_product;

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = BUSY;
            end
            BUSY: begin
                if (w_last) w_next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_p       <= '0;
            r_mcand   <= '0;
            r_iter    <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand <= a;
                        r_p     <= {1'b0, {WIDTH{1'b0}}, b};
                        r_iter  <= '0;
                    end
                end
                BUSY: begin
                    r_p    <= w_shifted;
                    r_iter <= r_iter + 4'd1;
                    if (w_last) r_product <= w_shifted[15:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_mult8.md
SEQ_MULT8 -- requirements
Module: seq_mult8

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits and product width at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operands a/b are presented.
REQ-005 in_ready  output  1  block can accept operands; high only in IDLE.
REQ-006 a  input  8  multiplicand, unsigned.
REQ-007 b  input  8  multiplier, unsigned.
REQ-008 out_valid  output  1  product is valid; high only in DONE.
REQ-009 out_ready  input  1  consumer accepts the product.
REQ-010 product  output  16  unsigned a*b.

Function
REQ-011 The block SHALL implement a shift-add multiplier with three states: IDLE, BUSY and DONE.
REQ-012 Operands are accepted on a rising edge where in_valid=1 and in_ready=1; a is latched into mcand, {acc=0, mplier=b} is loaded into the 17-bit register P={c,acc[7:0],mplier[7:0]}, iter count=0, and state goes IDLE->BUSY.
REQ-013 Each BUSY edge: if P[0]=1, {c,acc} SHALL be set to {cout,sum} of acc+mcand (cin=0); otherwise {c,acc}={0,acc}; then P SHALL be shifted right by one with c entering bit 15; iter count increments.
REQ-014 BUSY SHALL last exactly 8 edges; on the 8th BUSY edge state goes BUSY->DONE, so out_valid is high after the 8th edge following the accepting edge.
REQ-015 product SHALL equal P[15:0] in DONE and SHALL be held stable while out_valid=1 and out_ready=0.
REQ-016 DONE->IDLE occurs on the edge where out_ready=1; product SHALL keep its last value in IDLE.
REQ-017 in_valid SHALL be ignored in BUSY and DONE; no operand is lost, since in_ready is low in those states.
REQ-018 Arithmetic SHALL be unsigned; no overflow is possible (max 255*255=0xFE01); the adder carry is never discarded.
REQ-019 out_ready while not in DONE SHALL have no effect.

Reset
REQ-020 When rst=1 on an edge, state SHALL become IDLE, P=0, mcand=0, iter count=0, product=0, out_valid=0 and in_ready=1 after that edge.
REQ-021 rst SHALL take priority over every handshake, including in the middle of BUSY or DONE; an interrupted operation is discarded with no output.
REQ-022 rst SHALL be synchronous only; there is no asynchronous path.

Structure
REQ-023 The shared package mult8_pkg SHALL hold the state typedef (IDLE/BUSY/DONE), WIDTH=8 and ITERS=8.
REQ-024 The 8-bit add SHALL use one instance of the existing adder8bit ripple adder, with cin tied to 0; no other arithmetic operator is used for the add.
REQ-025 The iteration counter SHALL be 4 bits wide; the FSM and datapath registers SHALL reside in seq_mult8.

Verification
REQ-026 a=13, b=11, accepted; out_ready=1 -> product=0x008F (143) with out_valid high 8 edges after acceptance.
REQ-027 a=255, b=255 -> product=0xFE01; a=0, b=200 -> 0x0000; a=200, b=1 -> 0x00C8.
REQ-028 a=7, b=9 accepted; out_ready=0 for 5 cycles after DONE -> product=0x003F held, out_valid held; in_ready=0 throughout; out_ready=1 -> IDLE on the next edge.
REQ-029 in_valid held high with changing a/b during BUSY -> the result reflects only the first accepted pair; the next pair is accepted only after DONE->IDLE.
REQ-030 rst=1 at the 4th BUSY edge of a=100, b=100 -> out_valid=0, product=0, in_ready=1 after that edge; a following 3*5 -> 0x000F.
